// File: rtl/tile_fetch_if.sv
// rtl/tile_fetch_if.sv - read bus between the tile prefetcher and memory
interface tile_fetch_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/tile_fetch.sv
// rtl/tile_fetch.sv - tile-row prefetcher feeding a double-buffered tile renderer
// Optional TILE_FETCH_UNDERRUN_EN: a late fetch sets a sticky underrun flag instead of being aborted.
module tile_fetch #(
  parameter logic [9:0] FETCH_COL = 10'd160,
  parameter logic [8:0] LAST_ROW  = 9'd479
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [8:0]   row_i,
  input  logic [9:0]   col_i,
  tile_fetch_if.master bus,
  output logic [7:0]   tile_ROM_addr_o,
  output logic [5:0]   palette_ROM_addr_o,
  output logic         fetch_busy_o,
  output logic         underrun_o
);
  typedef enum logic [2:0] {IDLE, RD_TILE, RD_PAL, ADV, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  c_q, c_d;
  logic [3:0]  tgt_q, tgt_d;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic        ready_q, ready_d;
  logic [7:0]  back_tile_q  [16];
  logic [5:0]  back_pal_q   [16];
  logic [7:0]  front_tile_q [16];
  logic [5:0]  front_pal_q  [16];
  logic [7:0]  tile_q;
  logic [5:0]  pal_q;
  logic        cap_tile, cap_pal, do_swap;
  logic        trigger, swap_pt, displayed;
  logic [3:0]  trig_tgt;
  logic [8:0]  offset;
`ifdef TILE_FETCH_UNDERRUN_EN
  logic        underrun_q, underrun_d;
`endif

  assign trigger   = (col_i == FETCH_COL) &&
                     (((row_i[2:0] == 3'd7) && (row_i < 9'd120)) || (row_i == LAST_ROW));
  assign trig_tgt  = (row_i == LAST_ROW) ? 4'd0 : row_i[6:3] + 4'd1;
  assign swap_pt   = (col_i == 10'd0) && (row_i[2:0] == 3'd0) && (row_i < 9'd128);
  assign displayed = (row_i < 9'd128) && (col_i < 10'd128);
  assign offset    = {tgt_q, 5'b0} + {5'b0, c_q};

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    tgt_d    = tgt_q;
    req_d    = req_q;
    addr_d   = addr_q;
    ready_d  = ready_q;
    cap_tile = 1'b0;
    cap_pal  = 1'b0;
    do_swap  = 1'b0;
`ifdef TILE_FETCH_UNDERRUN_EN
    underrun_d = underrun_q;
`endif
    // Each read raises req for one fresh cycle, so the cycle after an ack is always idle on the bus.
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = RD_TILE;
          c_d     = 4'd0;
          tgt_d   = trig_tgt;
        end
      end
      RD_TILE: begin
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = 16'h4000 + {7'b0, offset};
        end else if (bus.mem_ack) begin
          req_d    = 1'b0;
          cap_tile = 1'b1;
          state_d  = RD_PAL;
        end
      end
      RD_PAL: begin
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = 16'h4400 + {7'b0, offset};
        end else if (bus.mem_ack) begin
          req_d   = 1'b0;
          cap_pal = 1'b1;
          state_d = ADV;
        end
      end
      ADV: begin
        if (c_q == 4'd15) begin
          state_d = DONE;
          ready_d = 1'b1;
        end else begin
          c_d     = c_q + 4'd1;
          state_d = RD_TILE;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    if (swap_pt) begin
      if (ready_q) begin
        do_swap = 1'b1;
        ready_d = 1'b0;
        state_d = IDLE;
      end else begin
`ifdef TILE_FETCH_UNDERRUN_EN
        underrun_d = 1'b1;
`else
        state_d  = IDLE;
        req_d    = 1'b0;
        cap_tile = 1'b0;
        cap_pal  = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      c_q     <= 4'd0;
      tgt_q   <= 4'd0;
      req_q   <= 1'b0;
      addr_q  <= 16'h0000;
      ready_q <= 1'b0;
      tile_q  <= 8'h00;
      pal_q   <= 6'h00;
      for (int i = 0; i < 16; i++) begin
        back_tile_q[i]  <= 8'h00;
        back_pal_q[i]   <= 6'h00;
        front_tile_q[i] <= 8'h00;
        front_pal_q[i]  <= 6'h00;
      end
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      tgt_q   <= tgt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      if (cap_tile) back_tile_q[c_q] <= bus.mem_rdata;
      if (cap_pal)  back_pal_q[c_q]  <= bus.mem_rdata[5:0];
      if (do_swap) begin
        for (int i = 0; i < 16; i++) begin
          front_tile_q[i] <= back_tile_q[i];
          front_pal_q[i]  <= back_pal_q[i];
        end
      end
      tile_q <= displayed ? front_tile_q[col_i[6:3]] : 8'h00;
      pal_q  <= displayed ? front_pal_q[col_i[6:3]]  : 6'h00;
    end
  end

`ifdef TILE_FETCH_UNDERRUN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) underrun_q <= 1'b0;
    else       underrun_q <= underrun_d;
  end
  assign underrun_o = underrun_q;
`else
  assign underrun_o = 1'b0;
`endif

  assign bus.mem_req        = req_q;
  assign bus.mem_addr       = addr_q;
  assign tile_ROM_addr_o    = tile_q;
  assign palette_ROM_addr_o = pal_q;
  assign fetch_busy_o       = (state_q == RD_TILE) || (state_q == RD_PAL) || (state_q == ADV);
endmodule

// File: tb/tb_tile_fetch.sv
// tb/tb_tile_fetch.sv - self-checking bench for tile_fetch with a memory responder and reference model
module tb_tile_fetch;
  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] row;
  logic [9:0] col;
  logic [7:0] tile_addr;
  logic [5:0] pal_addr;
  logic       busy, underrun;

  tile_fetch_if bus();

  tile_fetch dut (
    .clk_i(clk), .rst_i(rst), .row_i(row), .col_i(col), .bus(bus),
    .tile_ROM_addr_o(tile_addr), .palette_ROM_addr_o(pal_addr),
    .fetch_busy_o(busy), .underrun_o(underrun)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem [2048];
  logic [15:0] ack_log [$];
  int          wait_n = 1;
  bit          ack_en = 1'b1;
  bit          late_ack = 1'b0;
  int          stab_err = 0;
  logic [7:0]  m_back_t [16];
  logic [5:0]  m_back_p [16];
  logic [7:0]  m_front_t [16];
  logic [5:0]  m_front_p [16];

  // Memory responder: acks after wait_n idle cycles and logs every acknowledged address.
  initial begin : responder
    int          waited;
    logic        prev_req, prev_ack;
    logic [15:0] prev_addr;
    waited = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 16'h0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.mem_req && prev_req && !prev_ack && bus.mem_addr !== prev_addr) stab_err++;
      prev_req  = bus.mem_req;
      prev_addr = bus.mem_addr;
      if (late_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'hFF;
      end else if (bus.mem_req && ack_en && waited >= wait_n) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr[10:0]];
        ack_log.push_back(bus.mem_addr);
        waited = 0;
      end else begin
        bus.mem_ack = 1'b0;
        if (bus.mem_req) waited++;
        else waited = 0;
      end
      prev_ack = bus.mem_ack;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [8:0] r, input logic [9:0] c);
    row = r;
    col = c;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; row = 9'd200; col = 10'd200; late_ack = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    col = 10'd200;
    while ((busy || bus.mem_req) && n < 3000) begin
      cyc();
      n++;
    end
    check({nm, " completes"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic run_fetch(input logic [8:0] r, input string nm);
    drive(r, 10'd160);
    wait_idle(nm);
  endtask

  // Expected bus order for a target tile row: tile and palette reads interleaved per column.
  task automatic check_log(input logic [3:0] t, input string nm);
    logic [15:0] e, a;
    check({nm, " count"}, ack_log.size(), 32'd32);
    for (int k = 0; k < 32; k++) begin
      e = ((k % 2) ? 16'h4400 : 16'h4000) + 16'(t) * 16'd32 + 16'(k / 2);
      a = (k < ack_log.size()) ? ack_log[k] : 16'h0000;
      check($sformatf("%s addr[%0d]", nm, k), a, e);
    end
  endtask

  task automatic model_fetch(input logic [3:0] t);
    for (int c = 0; c < 16; c++) begin
      m_back_t[c] = mem[int'(t) * 32 + c];
      m_back_p[c] = mem[12'h400 + int'(t) * 32 + c][5:0];
    end
  endtask

  typedef struct {
    logic [8:0]  r;
    logic [9:0]  c;
    bit          trig;
    logic [15:0] addr;
  } trig_vec_t;

  typedef struct {
    logic [8:0] r;
    logic [9:0] c;
    logic [7:0] tile;
    logic [5:0] pal;
  } disp_vec_t;

  trig_vec_t tv [10];
  disp_vec_t dv [10];

  initial begin : main
    bit         seen;
    logic [15:0] a;
    int         n;
    logic [3:0] t;
    logic [8:0] r;
    logic [9:0] c;

    tv[0] = '{9'd7,   10'd160, 1'b1, 16'h4020};
    tv[1] = '{9'd479, 10'd160, 1'b1, 16'h4000};
    tv[2] = '{9'd500, 10'd160, 1'b0, 16'h0000};
    tv[3] = '{9'd119, 10'd160, 1'b1, 16'h41E0};
    tv[4] = '{9'd111, 10'd160, 1'b1, 16'h41C0};
    tv[5] = '{9'd127, 10'd160, 1'b0, 16'h0000};
    tv[6] = '{9'd7,   10'd159, 1'b0, 16'h0000};
    tv[7] = '{9'd6,   10'd160, 1'b0, 16'h0000};
    tv[8] = '{9'd15,  10'd161, 1'b0, 16'h0000};
    tv[9] = '{9'd63,  10'd160, 1'b1, 16'h4100};

    dv[0] = '{9'd8,   10'd24,   8'hA5, 6'h12};
    dv[1] = '{9'd9,   10'd31,   8'hA5, 6'h12};
    dv[2] = '{9'd8,   10'd127,  8'h1F, 6'h0F};
    dv[3] = '{9'd9,   10'd0,    8'h10, 6'h00};
    dv[4] = '{9'd10,  10'd8,    8'h11, 6'h01};
    dv[5] = '{9'd8,   10'd128,  8'h00, 6'h00};
    dv[6] = '{9'd128, 10'd24,   8'h00, 6'h00};
    dv[7] = '{9'd200, 10'd8,    8'h00, 6'h00};
    dv[8] = '{9'd127, 10'd120,  8'h1F, 6'h0F};
    dv[9] = '{9'd12,  10'd1023, 8'h00, 6'h00};

    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      mem[12'h020 + i] = 8'h10 + 8'(i);
      mem[12'h420 + i] = 8'hC0 + 8'(i);
    end
    mem[12'h023] = 8'hA5;
    mem[12'h423] = 8'hD2;

    // Reset values while reset is held.
    rst = 1'b1; row = 9'd200; col = 10'd200;
    cyc();
    cyc();
    check("reset mem_req", bus.mem_req, 1'b0);
    check("reset mem_addr", bus.mem_addr, 16'h0);
    check("reset tile", tile_addr, 8'h0);
    check("reset pal", pal_addr, 6'h0);
    check("reset busy", busy, 1'b0);
    check("reset underrun", underrun, 1'b0);
    rst = 1'b0;

    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.mem_req || busy) seen = 1'b1;
    end
    check("no implicit fetch", seen, 1'b0);

    // Trigger decode table.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      ack_en = 1'b0;
      drive(tv[i].r, tv[i].c);
      col = 10'd200;
      seen = 1'b0;
      a = 16'h0;
      for (int k = 0; k < 4; k++) begin
        cyc();
        if (bus.mem_req && !seen) begin
          seen = 1'b1;
          a = bus.mem_addr;
        end
      end
      check($sformatf("trigger r%0d c%0d", tv[i].r, tv[i].c), seen, tv[i].trig);
      if (tv[i].trig) check($sformatf("first addr r%0d", tv[i].r), a, tv[i].addr);
    end

    // Full fetch of tile row 1 with one wait cycle, then swap and read back via the display table.
    do_reset();
    ack_en = 1'b1;
    wait_n = 1;
    ack_log.delete();
    stab_err = 0;
    run_fetch(9'd7, "row1");
    check_log(4'd1, "row1");
    check("req/addr stable", stab_err, 0);
    drive(9'd8, 10'd0);
    for (int i = 0; i < 10; i++) begin
      drive(dv[i].r, dv[i].c);
      check($sformatf("tile r%0d c%0d", dv[i].r, dv[i].c), tile_addr, dv[i].tile);
      check($sformatf("pal r%0d c%0d", dv[i].r, dv[i].c), pal_addr, dv[i].pal);
    end

    // Retrigger during a fetch must not disturb it.
    do_reset();
    ack_log.delete();
    drive(9'd7, 10'd160);
    col = 10'd200;
    repeat (20) cyc();
    drive(9'd23, 10'd160);
    wait_idle("retrigger");
    check_log(4'd1, "retrigger");

    // Missed swap: stalled fetch of tile row 2 at the row 16 swap point.
    drive(9'd8, 10'd0);
    drive(9'd17, 10'd24);
    check("pre-miss tile", tile_addr, 8'hA5);
    ack_en = 1'b0;
    drive(9'd15, 10'd160);
    col = 10'd200;
    repeat (10) cyc();
    check("stalled busy", busy, 1'b1);
    drive(9'd16, 10'd0);
`ifdef TILE_FETCH_UNDERRUN_EN
    check("miss underrun", underrun, 1'b1);
    check("miss busy kept", busy, 1'b1);
`else
    check("miss mem_req", bus.mem_req, 1'b0);
    check("miss busy", busy, 1'b0);
    check("miss underrun", underrun, 1'b0);
`endif
    drive(9'd17, 10'd24);
    check("front kept tile", tile_addr, 8'hA5);
    check("front kept pal", pal_addr, 6'h12);
`ifdef TILE_FETCH_UNDERRUN_EN
    ack_en = 1'b1;
    wait_idle("late fetch");
    check("underrun sticky", underrun, 1'b1);
    drive(9'd16, 10'd0);
    drive(9'd17, 10'd0);
    check("late swap tile", tile_addr, mem[12'h040]);
    check("late swap pal", pal_addr, mem[12'h440][5:0]);
`endif

    // Reset in the middle of a request, followed by a stray ack.
    do_reset();
    ack_en = 1'b0;
    drive(9'd7, 10'd160);
    col = 10'd200;
    n = 0;
    while (!bus.mem_req && n < 10) begin
      cyc();
      n++;
    end
    check("req before reset", bus.mem_req, 1'b1);
    rst = 1'b1;
    cyc();
    check("rst mem_req", bus.mem_req, 1'b0);
    check("rst mem_addr", bus.mem_addr, 16'h0);
    check("rst busy", busy, 1'b0);
    check("rst underrun", underrun, 1'b0);
    rst = 1'b0;
    late_ack = 1'b1;
    cyc();
    cyc();
    late_ack = 1'b0;
    cyc();
    check("late ack busy", busy, 1'b0);
    check("late ack req", bus.mem_req, 1'b0);
    drive(9'd9, 10'd24);
    check("post-reset tile", tile_addr, 8'h00);
    check("post-reset pal", pal_addr, 6'h00);

    // Randomized frames against the reference model.
    do_reset();
    ack_en = 1'b1;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    for (int it = 0; it < 10; it++) begin
      t = 4'($urandom_range(0, 15));
      wait_n = $urandom_range(0, 3);
      ack_log.delete();
      run_fetch((t == 4'd0) ? 9'd479 : 9'(8 * (int'(t) - 1) + 7), $sformatf("rand%0d", it));
      check_log(t, $sformatf("rand%0d t%0d", it, t));
      model_fetch(t);
      drive(9'(8 * int'(t)), 10'd0);
      m_front_t = m_back_t;
      m_front_p = m_back_p;
      for (int j = 0; j < 24; j++) begin
        if ($urandom_range(0, 1) == 0) begin
          r = 9'($urandom_range(0, 127));
          c = 10'($urandom_range(0, 127));
        end else begin
          r = 9'($urandom_range(0, 511));
          c = 10'($urandom_range(0, 1023));
        end
        if (c == 10'd0 && r[2:0] == 3'd0) c = 10'd1;
        if (c == 10'd160) c = 10'd161;
        drive(r, c);
        check($sformatf("rand tile r%0d c%0d", r, c), tile_addr,
              (r < 128 && c < 128) ? m_front_t[c[6:3]] : 8'h00);
        check($sformatf("rand pal r%0d c%0d", r, c), pal_addr,
              (r < 128 && c < 128) ? m_front_p[c[6:3]] : 6'h00);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tile_fetch.md
TILE_FETCH -- requirements
Module: tile_fetch

Interface
REQ-001 Parameter FETCH_COL, default 10'd160, column at which a tile-row prefetch is triggered.
REQ-002 Parameter LAST_ROW, default 9'd479, final scanline of the frame; prefetch of tile row 0 triggers on it.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 row  input  9  current scanline from the video timing generator.
REQ-006 col  input  10  current pixel column from the video timing generator.
REQ-007 mem_req  output  1  bus read request.
REQ-008 mem_addr  output  16  bus read address.
REQ-009 mem_ack  input  1  bus acknowledge; mem_rdata is valid in the same cycle.
REQ-010 mem_rdata  input  8  bus read data.
REQ-011 tile_ROM_addr  output  8  tile code for the pixel at (row,col), delivered to the tile renderer.
REQ-012 palette_ROM_addr  output  6  palette index for the pixel at (row,col), delivered to the tile renderer.
REQ-013 fetch_busy  output  1  high while a prefetch is in progress.
REQ-014 underrun  output  1  sticky flag: a buffer swap was due before its prefetch completed.

Function
REQ-015 Screen is 16x16 tiles of 8x8 px; tile_row = row[6:3], tile_col = col[6:3]; only row<128 and col<128 are displayed.
REQ-016 Two 16-entry buffers (front and back), each entry holding {tile code [7:0], palette [5:0]}; the renderer reads only front.
REQ-017 Trigger: when col==FETCH_COL and either (row[2:0]==7 and row<9'd120) or row==LAST_ROW; target tile row = row[6:3]+1, or 0 on LAST_ROW.
REQ-018 Triggers arriving while fetch_busy=1 are ignored.
REQ-019 FSM states: IDLE, RD_TILE, RD_PAL, ADV, DONE; IDLE->RD_TILE on trigger, with column counter c cleared to 0.
REQ-020 RD_TILE: mem_addr = 16'h4000 + {tgt_row,5'b0} + c; RD_PAL: mem_addr = 16'h4400 + the same offset.
REQ-021 mem_req and mem_addr are held stable from assertion until the cycle mem_ack=1; mem_rdata is captured into back[c] in that cycle.
REQ-022 mem_req deasserts in the cycle after ack; the next request is issued no earlier than the following cycle.
REQ-023 Transitions: RD_TILE-ack->RD_PAL; RD_PAL-ack->ADV (palette = mem_rdata[5:0]); ADV: c==15 -> DONE, else c+1 and ->RD_TILE.
REQ-024 DONE holds a ready flag until the swap, then returns to IDLE; a fetch comprises exactly 32 bus transactions.
REQ-025 Swap: at col==0 when row[2:0]==0 and row<128, if ready, front<=back and ready is cleared.
REQ-026 If a swap is due and ready=0, front is kept unchanged and the underrun behaviour of REQ-033/034 applies.
REQ-027 tile_ROM_addr and palette_ROM_addr are registered from front[col[6:3]] with 1-cycle latency; both read 0 whenever col>=128 or row>=128.
REQ-028 fetch_busy = 1 in RD_TILE, RD_PAL and ADV; 0 otherwise.
REQ-029 Column counter is 4 bits; the address offset is {tgt_row[3:0],5'b0}+c with no carry into the base.

Reset
REQ-030 rst=1 forces state IDLE, c=0, ready=0, both buffers zero, mem_req=0, mem_addr=0, tile_ROM_addr=0, palette_ROM_addr=0, fetch_busy=0 and underrun=0.
REQ-031 rst asserted mid-fetch abandons the transaction; mem_req=0 in the cycle after rst is sampled, and a mem_ack arriving after that is ignored.
REQ-032 After rst, the first prefetch is started by the next trigger; no implicit fetch occurs.

Configuration
REQ-033 With TILE_FETCH_UNDERRUN_EN defined, a missed swap sets underrun, which stays set until rst, and the in-progress fetch continues; its buffer is swapped at the next swap point.
REQ-034 Without TILE_FETCH_UNDERRUN_EN, underrun is tied to 0, and a missed swap aborts any in-progress fetch (state->IDLE, mem_req dropped).

Verification
REQ-035 Bus acking every request after 1 wait cycle, row=7, col=160 trigger -> 32 requests at 0x4020..0x402F (tile) and 0x4420..0x442F (palette), interleaved, then ready=1.
REQ-036 Tile row 1 fetched with back[3]={8'hA5,6'h12}; at row=8, col=24 -> tile_ROM_addr=8'hA5 and palette_ROM_addr=6'h12 one cycle later.
REQ-037 row=479, col=160 -> first mem_addr=16'h4000; at row=500, col=160 -> no request.
REQ-038 Bus never acks after trigger on row 15 -> at row=16, col=0: front unchanged; underrun=1 with macro, mem_req=0 next cycle without.
REQ-039 rst pulse while mem_req=1 -> mem_req=0 and all outputs 0 next cycle; a late ack writes nothing.
REQ-040 A second trigger during a fetch -> request sequence unchanged and c is not restarted.
